// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 5-stage RV32I pipe: stage enables/clears, load-use stall, branch flush, dmem wait.
// Latency: enable/clear strobes are combinational from state and inputs; state updates on the next clk.
// Backpressure: a pending dmem access freezes all stages; PIPE_HAZARD_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned INIT_CYC    = 2,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rd_E,
    input  logic             memread_E,
    input  logic             pcsrc_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready_M,
    output logic             en_PC,
    output logic             en_F_D,
    output logic             clr_F_D,
    output logic             en_D_E,
    output logic             clr_D_E,
    output logic             en_E_M,
    output logic             clr_M_W,
    output logic [1:0]       state_o,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_HALT = 2'd3
    } state_t;

    typedef struct packed {
        logic en_pc;
        logic en_fd;
        logic clr_fd;
        logic en_de;
        logic clr_de;
        logic en_em;
        logic clr_mw;
    } ctl_t;

    localparam ctl_t CTL_BUBBLE = ctl_t'(7'b0111111);
    localparam ctl_t CTL_FREEZE = ctl_t'(7'b0000001);
    localparam ctl_t CTL_FLUSH  = ctl_t'(7'b1111110);
    localparam ctl_t CTL_LU     = ctl_t'(7'b0001110);
    localparam ctl_t CTL_NORMAL = ctl_t'(7'b1101010);

    localparam int unsigned INIT_EFF  = (INIT_CYC == 0) ? 1 : INIT_CYC;
    localparam logic [31:0] INIT_LAST = 32'(INIT_EFF - 1);
    localparam bit          TO_EN     = (MEM_TIMEOUT != 0);
    localparam logic [15:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? 16'd0 : 16'(MEM_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] init_cnt;
    logic [15:0] wait_cnt;
    logic        load_use, freeze_req;
    logic        wait_clr, wait_inc, err_set;
    ctl_t        run_ctl, ctl;

    assign load_use   = memread_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    assign freeze_req = dmem_req_M && !dmem_ready_M;

    // A taken branch squashes the stalled instruction, so flush outranks load-use.
    always_comb begin
        run_ctl = CTL_NORMAL;
        if (pcsrc_E) begin
            run_ctl = CTL_FLUSH;
        end else if (load_use) begin
            run_ctl = CTL_LU;
        end
    end

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_INIT: begin
                ctl = CTL_BUBBLE;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (freeze_req) begin
                    ctl       = CTL_FREEZE;
                    state_nxt = S_WAIT;
                    wait_clr  = 1'b1;
                end else begin
                    ctl = run_ctl;
                end
            end
            S_WAIT: begin
                if (dmem_ready_M) begin
                    ctl       = run_ctl;
                    state_nxt = S_RUN;
                end else begin
                    ctl = CTL_FREEZE;
                    if (TO_EN && (wait_cnt == WAIT_LAST)) begin
                        state_nxt = S_HALT;
                        err_set   = 1'b1;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end
            end
            default: begin
                ctl = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) begin
                init_cnt <= init_cnt + 32'd1;
            end
            if (wait_clr) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (err_set) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign en_PC   = ctl.en_pc;
    assign en_F_D  = ctl.en_fd;
    assign clr_F_D = ctl.clr_fd;
    assign en_D_E  = ctl.en_de;
    assign clr_D_E = ctl.clr_de;
    assign en_E_M  = ctl.en_em;
    assign clr_M_W = ctl.clr_mw;
    assign state_o = state;

`ifdef PIPE_HAZARD_PERF_EN
    logic             stall_evt, flush_evt;
    logic [CNT_W-1:0] stall_q, flush_q;

    assign stall_evt = ((state == S_RUN) || (state == S_WAIT)) && !ctl.en_pc;
    assign flush_evt = pcsrc_E && (((state == S_RUN) && !freeze_req) ||
                                   ((state == S_WAIT) && dmem_ready_M));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_evt && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic against a cycle model.
module tb_pipe_hazard_ctrl;

    localparam int INIT_CYC    = 2;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_D, rs2_D, rd_E;
    logic             memread_E, pcsrc_E, dmem_req_M, dmem_ready_M;
    logic             en_PC, en_F_D, clr_F_D, en_D_E, clr_D_E, en_E_M, clr_M_W;
    logic [1:0]       state_o;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: mode 0=INIT 1=RUN 2=WAIT 3=HALT
    int m_mode, m_init, m_wait, m_stall, m_flush;
    bit m_err;

    pipe_hazard_ctrl #(
        .INIT_CYC(INIT_CYC), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_E(rd_E),
        .memread_E(memread_E), .pcsrc_E(pcsrc_E),
        .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
        .en_PC(en_PC), .en_F_D(en_F_D), .clr_F_D(clr_F_D),
        .en_D_E(en_D_E), .clr_D_E(clr_D_E), .en_E_M(en_E_M), .clr_M_W(clr_M_W),
        .state_o(state_o), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_init = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
    endtask

    // One clock: drive at negedge, compare just after, advance model for the coming posedge.
    task automatic step(input bit r, input bit mr, input bit pc, input bit rq, input bit rdy,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        logic [6:0] e;
        bit         lu, frz, fl;
        @(negedge clk);
        rst = r; memread_E = mr; pcsrc_E = pc; dmem_req_M = rq; dmem_ready_M = rdy;
        rs1_D = a; rs2_D = b; rd_E = d;
        #1;
        lu  = mr && (d != 0) && (d == a || d == b);
        frz = (m_mode == 1) ? (rq && !rdy) : !rdy;
        fl  = 1'b0;
        if (m_mode == 0)      e = 7'b0111111;
        else if (m_mode == 3) e = 7'b0000000;
        else if (frz)         e = 7'b0000001;
        else if (pc)          begin e = 7'b1111110; fl = 1'b1; end
        else if (lu)          e = 7'b0001110;
        else                  e = 7'b1101010;
        chk("ctl", {25'd0, en_PC, en_F_D, clr_F_D, en_D_E, clr_D_E, en_E_M, clr_M_W}, {25'd0, e});
        chk("state", {30'd0, state_o}, m_mode);
        chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
`ifdef PIPE_HAZARD_PERF_EN
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
        chk("flush_cnt", {16'd0, flush_cnt}, m_flush);
`else
        chk("stall_cnt", {16'd0, stall_cnt}, 0);
        chk("flush_cnt", {16'd0, flush_cnt}, 0);
`endif
        if (r) begin
            model_reset();
        end else begin
            if (m_mode == 1 || m_mode == 2) begin
                if (!e[6]) m_stall++;
                if (fl)    m_flush++;
            end
            case (m_mode)
                0: begin
                    m_init++;
                    if (m_init >= INIT_CYC) m_mode = 1;
                end
                1: if (rq && !rdy) begin m_mode = 2; m_wait = 0; end
                2: begin
                    if (rdy) m_mode = 1;
                    else if (m_wait == MEM_TIMEOUT - 1) begin m_mode = 3; m_err = 1'b1; end
                    else m_wait++;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        rst = 1'b1; memread_E = 0; pcsrc_E = 0; dmem_req_M = 0; dmem_ready_M = 0;
        rs1_D = 0; rs2_D = 0; rd_E = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset warm-up: two bubble cycles, then RUN
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
        chk("warm_state", {30'd0, state_o}, 1);

        // Load-use with rd_E=5 hitting rs2, then rd_E=0 which must not stall
        step(0, 1, 0, 0, 0, 5'd1, 5'd5, 5'd5);
        step(0, 0, 0, 0, 0, 5'd1, 5'd5, 5'd6);
        step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 0, 5'd5, 5'd0, 5'd0);

        // Flush with a simultaneous load-use hazard
        step(0, 1, 1, 0, 0, 5'd7, 5'd2, 5'd7);
        step(0, 0, 0, 0, 0, 5'd7, 5'd2, 5'd3);

        // Memory wait: three frozen cycles then release
        repeat (3) step(0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
        step(0, 0, 0, 1, 1, 5'd1, 5'd2, 5'd3);
        step(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);

        // Freeze beats flush; flush is applied on the release cycle
        repeat (2) step(0, 0, 1, 1, 0, 5'd1, 5'd2, 5'd3);
        step(0, 0, 1, 1, 1, 5'd1, 5'd2, 5'd3);
        step(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3);

        // Timeout into HALT, HALT ignores inputs, reset recovers
        repeat (10) step(0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
        chk("halt_state", {30'd0, state_o}, 3);
        chk("halt_err", {31'd0, mem_err}, 1);
        step(0, 1, 1, 1, 1, 5'd4, 5'd4, 5'd4);
        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        chk("post_rst_err", {31'd0, mem_err}, 0);
        repeat (3) step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        // Random traffic with small register numbers to provoke hazards
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
